// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared state encoding and constants for the program loader
package dsp_pkg;
  localparam int WORD_W    = 16;
  localparam int DEPTH_DEF = 64;
  localparam int TMO_DEF   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOADED,
    ST_RUN,
    ST_FIN
  } state_t;
endpackage

// File: rtl/run_timer.sv
// rtl/run_timer.sv - run watchdog counter, flags the last permitted run cycle
module run_timer
  import dsp_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic c,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);

  logic [CW-1:0] count;

  always_ff @(posedge c) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + 1'b1;
  end

  // High during the TMO-th enabled cycle, so the run lasts exactly TMO cycles.
  assign expired = enable && (count == LAST);
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into processor memory and supervises its run
module prog_loader
  import dsp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 6,
  parameter int TMO   = TMO_DEF
) (
  input  logic              c,
  input  logic              rst,
  input  logic [0:WORD_W-1] host_din,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_last,
  input  logic              go,
  input  logic              proc_done,
  output logic [AW-1:0]     mem_addr,
  output logic [0:WORD_W-1] mem_wdata,
  output logic              mem_we,
  output logic              ext,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       word_cnt,
  output logic              err
);
  localparam logic [AW:0] LAST_SLOT = (AW + 1)'(DEPTH - 1);

  state_t state, state_n;
  logic   xfer, last_word, go_ok, go_bad, expired, timeout;

  assign host_ready = !rst && (state == ST_IDLE || state == ST_LOAD);
  assign xfer       = host_valid && host_ready;
  assign last_word  = host_last || (word_cnt == LAST_SLOT);
  assign go_ok      = go && (state == ST_LOADED || (state == ST_LOAD && word_cnt != '0));
  assign go_bad     = go && (state == ST_IDLE || (state == ST_LOAD && word_cnt == '0));
  assign timeout    = (state == ST_RUN) && expired && !proc_done;

  assign ext  = (state == ST_RUN);
  assign done = (state == ST_FIN);
  assign busy = (state == ST_LOAD) || (state == ST_LOADED) || (state == ST_RUN);

  run_timer #(.TMO(TMO)) u_timer (
    .c       (c),
    .rst     (rst),
    .enable  (state == ST_RUN),
    .clear   (state != ST_RUN),
    .expired (expired)
  );

  always_ff @(posedge c) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // A go that arrives with a transfer wins over host_last: the word lands, then RUN.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (xfer) state_n = last_word ? ST_LOADED : ST_LOAD;
      ST_LOAD: begin
        if (go_ok)                  state_n = ST_RUN;
        else if (xfer && last_word) state_n = ST_LOADED;
      end
      ST_LOADED: if (go_ok) state_n = ST_RUN;
      ST_RUN: begin
        if (proc_done)    state_n = ST_FIN;
        else if (expired) state_n = ST_IDLE;
      end
      ST_FIN:    state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= xfer;
      if (xfer) begin
        mem_addr  <= word_cnt[AW-1:0];
        mem_wdata <= host_din;
      end
      if (state == ST_FIN || timeout) word_cnt <= '0;
      else if (xfer)                  word_cnt <= word_cnt + 1'b1;
      if (go_bad || timeout) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;
  import dsp_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int TMO   = 24;

  localparam int P_IDLE = 0, P_LOAD = 1, P_LOADED = 2, P_RUN = 3, P_FIN = 4;

  logic              c = 1'b0;
  logic              rst = 1'b1;
  logic [0:WORD_W-1] host_din = '0;
  logic              host_valid = 1'b0, host_last = 1'b0, go = 1'b0, proc_done = 1'b0;
  logic              host_ready, mem_we, ext, busy, done, err;
  logic [AW-1:0]     mem_addr;
  logic [0:WORD_W-1] mem_wdata;
  logic [AW:0]       word_cnt;

  prog_loader #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
    .c          (c),
    .rst        (rst),
    .host_din   (host_din),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_last  (host_last),
    .go         (go),
    .proc_done  (proc_done),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .ext        (ext),
    .busy       (busy),
    .done       (done),
    .word_cnt   (word_cnt),
    .err        (err)
  );

  always #5 c = ~c;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t sbq[$];
  int  nvec = 0, nfail = 0, cyc = 0;
  int  ph = P_IDLE, m_cnt = 0, m_run = 0;
  bit  m_err = 1'b0;

  always @(posedge c) cyc++;

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge c) begin
    wr_t e;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      chk("write_missing", 0, 1);
      void'(sbq.pop_front());
    end
    if (mem_we) begin
      if (sbq.size() == 0) chk("write_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", int'(mem_addr), e.addr);
        chk("write_data", int'(mem_wdata), e.data);
      end
    end
  end

  // One clock of stimulus: check visible outputs against the model, then advance it.
  task automatic step(bit r, bit hv, logic [15:0] hd, bit hl, bit g, bit pd);
    bit rdy, xfer, had;
    rst = r; host_valid = hv; host_din = hd; host_last = hl; go = g; proc_done = pd;
    @(negedge c);
    rdy = !r && (ph == P_IDLE || ph == P_LOAD);
    chk("host_ready", int'(host_ready), int'(rdy));
    chk("ext", int'(ext), int'(ph == P_RUN));
    chk("done", int'(done), int'(ph == P_FIN));
    chk("busy", int'(busy), int'(ph == P_LOAD || ph == P_LOADED || ph == P_RUN));
    chk("err", int'(err), int'(m_err));
    chk("word_cnt", int'(word_cnt), m_cnt);
    if (r) begin
      ph = P_IDLE; m_cnt = 0; m_run = 0; m_err = 1'b0;
    end else begin
      xfer = hv && rdy;
      had  = (m_cnt > 0);
      if (xfer) sbq.push_back('{cyc + 1, m_cnt, int'(hd)});
      case (ph)
        P_IDLE: begin
          if (g) m_err = 1'b1;
          if (xfer) begin
            m_cnt++;
            ph = (hl || m_cnt == DEPTH) ? P_LOADED : P_LOAD;
          end
        end
        P_LOAD: begin
          if (xfer) m_cnt++;
          if (g && had) begin ph = P_RUN; m_run = 0; end
          else if (g) m_err = 1'b1;
          else if (xfer && (hl || m_cnt == DEPTH)) ph = P_LOADED;
        end
        P_LOADED: if (g) begin ph = P_RUN; m_run = 0; end
        P_RUN: begin
          m_run++;
          if (pd) ph = P_FIN;
          else if (m_run == TMO) begin m_err = 1'b1; ph = P_IDLE; m_cnt = 0; end
        end
        default: begin ph = P_IDLE; m_cnt = 0; end
      endcase
    end
    @(posedge c);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    @(posedge c);
    #1;
    step(1, 0, 16'h0, 0, 0, 0);
    step(1, 1, 16'hffff, 0, 1, 0);
    idle(1);

    // Full-depth stream, data equals address; extra word while LOADED is refused.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(i), 0, 0, 0);
    step(0, 1, 16'($urandom), 0, 0, 0);
    step(0, 0, 16'h0, 0, 1, 1);
    idle(4);
    step(0, 0, 16'h0, 0, 0, 1);
    idle(2);

    // Five words ending on host_last, proc_done on run cycle 20.
    for (int i = 1; i <= 5; i++) step(0, 1, 16'($urandom), i == 5, 0, 0);
    step(0, 0, 16'h0, 0, 1, 0);
    idle(19);
    step(0, 0, 16'h0, 0, 0, 1);
    idle(2);

    // go in IDLE sets err, stays IDLE.
    step(0, 0, 16'h0, 0, 1, 0);
    idle(2);
    step(1, 0, 16'h0, 0, 0, 0);
    idle(1);

    // go together with the third transfer.
    step(0, 1, 16'($urandom), 0, 0, 0);
    step(0, 1, 16'($urandom), 0, 0, 0);
    step(0, 1, 16'($urandom), 0, 1, 0);
    idle(3);
    step(0, 0, 16'h0, 0, 0, 1);
    idle(2);

    // Watchdog expiry without proc_done.
    step(0, 1, 16'($urandom), 0, 0, 0);
    step(0, 1, 16'($urandom), 1, 0, 0);
    step(0, 0, 16'h0, 0, 1, 0);
    idle(TMO + 3);
    step(0, 0, 16'h0, 0, 0, 1);
    step(1, 0, 16'h0, 0, 0, 0);

    // Reset lands on word 30 of a load.
    for (int i = 0; i < 29; i++) step(0, 1, 16'($urandom), 0, 0, 0);
    step(1, 1, 16'($urandom), 0, 0, 0);
    step(0, 1, 16'($urandom), 0, 0, 0);
    idle(2);
    step(1, 0, 16'h0, 0, 0, 0);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);

    idle(2);
    chk("queue_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
